cdce_spi_arbiter: RTL and testbench

Shares the single CDCE serial shift engine between two command sources:
- the boot-time configuration sequencer (cfg port);
- a runtime register-write port (rt port), e.g. output-divider retune from host logic.

It sits between the command sources and the serial-out engine. It accepts one 32-bit command word per transaction, launches the engine, waits for its completion and reports completion to the owning requester. Fixed cfg priority applies, with a starvation guard for rt.

---
 rtl/cdce_pkg.sv | 18 +
 rtl/cdce_arb_select.sv | 51 +++++
 rtl/cdce_spi_arbiter.sv | 136 +++++++++++++
 tb/tb_cdce_spi_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdce_pkg.sv
// Shared types for the CDCE serial-engine arbiter: command width, FSM states, owner encoding.
package cdce_pkg;

    localparam int unsigned CDCE_CMD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        COMPLETE
    } arb_state_e;

    typedef enum logic {
        OWN_CFG,
        OWN_RT
    } owner_e;

endpackage

// File: rtl/cdce_arb_select.sv
// Winner selection for the CDCE arbiter: cfg has priority, and a burst counter
// guarantees rt a grant after CFG_BURST consecutive cfg grants.
module cdce_arb_select
    import cdce_pkg::*;
#(
    parameter int unsigned CFG_BURST = 4
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   cfg_req,
    input  logic   rt_req,
    input  logic   idle,
    input  logic   grant,
    output owner_e owner
);

    logic [3:0] burst_q, burst_d;
    logic       burst_limit;

    assign burst_limit = (burst_q == 4'(CFG_BURST));

    always_comb begin
        owner = OWN_CFG;
        if (rt_req && (!cfg_req || burst_limit)) begin
            owner = OWN_RT;
        end
    end

    // Only cfg grants made while rt is waiting count towards the burst limit.
    always_comb begin
        burst_d = burst_q;
        if (idle && !rt_req) begin
            burst_d = '0;
        end else if (grant) begin
            if (owner == OWN_RT) begin
                burst_d = '0;
            end else begin
                burst_d = burst_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end

endmodule

// File: rtl/cdce_spi_arbiter.sv
// Shares the CDCE serial shift engine between the boot cfg sequencer and the runtime port.
// Define CDCE_ARB_WATCHDOG_EN to compile in the WAIT-state watchdog and sticky timeout flag.
module cdce_spi_arbiter
    import cdce_pkg::*;
#(
    parameter int unsigned CMD_W          = CDCE_CMD_W,
    parameter int unsigned CFG_BURST      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             cfg_req,
    input  logic [CMD_W-1:0] cfg_data,
    output logic             cfg_ack,
    output logic             cfg_done,
    input  logic             rt_req,
    input  logic [CMD_W-1:0] rt_data,
    output logic             rt_ack,
    output logic             rt_done,
    output logic             ser_start,
    output logic [CMD_W-1:0] ser_data,
    input  logic             ser_done,
    output logic             busy,
    output logic             timeout
);

    arb_state_e       state_q, state_d;
    owner_e           owner_q, sel_owner;
    logic [CMD_W-1:0] data_q;
    logic             grant;
    logic             wdog_expire;

    assign grant = (state_q == IDLE) && enable && (cfg_req || rt_req);

    cdce_arb_select #(
        .CFG_BURST (CFG_BURST)
    ) u_select (
        .clk     (clk),
        .reset_n (reset_n),
        .cfg_req (cfg_req),
        .rt_req  (rt_req),
        .idle    (state_q == IDLE),
        .grant   (grant),
        .owner   (sel_owner)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (grant) state_d = LAUNCH;
            LAUNCH:   state_d = WAIT;
            WAIT:     if (ser_done || wdog_expire) state_d = COMPLETE;
            COMPLETE: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        ser_start = 1'b0;
        cfg_ack   = 1'b0;
        rt_ack    = 1'b0;
        cfg_done  = 1'b0;
        rt_done   = 1'b0;
        busy      = (state_q != IDLE);
        unique case (state_q)
            LAUNCH: begin
                ser_start = 1'b1;
                cfg_ack   = (owner_q == OWN_CFG);
                rt_ack    = (owner_q == OWN_RT);
            end
            COMPLETE: begin
                cfg_done = (owner_q == OWN_CFG);
                rt_done  = (owner_q == OWN_RT);
            end
            default: ;
        endcase
    end

    // Word and owner are latched at grant so ser_data is stable through WAIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            owner_q <= OWN_CFG;
        end else if (grant) begin
            data_q  <= (sel_owner == OWN_RT) ? rt_data : cfg_data;
            owner_q <= sel_owner;
        end
    end

    assign ser_data = data_q;

`ifdef CDCE_ARB_WATCHDOG_EN
    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WdW-1:0] wdog_q;
    logic           timeout_q;

    // A done arriving in the expiry cycle wins; timeout is not flagged then.
    assign wdog_expire = (state_q == WAIT) && !ser_done &&
                         (wdog_q == WdW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q == LAUNCH) begin
                wdog_q <= '0;
            end else if (state_q == WAIT) begin
                wdog_q <= wdog_q + 1'b1;
            end
            if (wdog_expire) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_timeout_cycles;

    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign wdog_expire           = 1'b0;
    assign timeout               = 1'b0;
`endif

endmodule

// File: tb/tb_cdce_spi_arbiter.sv
// Directed bench for cdce_spi_arbiter with a start-order scoreboard and a simple engine model.
module tb_cdce_spi_arbiter;

    localparam int unsigned CMD_W = 32;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             enable = 1'b0;
    logic             cfg_req = 1'b0;
    logic [CMD_W-1:0] cfg_data = '0;
    logic             rt_req = 1'b0;
    logic [CMD_W-1:0] rt_data = '0;
    logic             ser_done = 1'b0;
    logic             cfg_ack, cfg_done, rt_ack, rt_done;
    logic             ser_start, busy, timeout;
    logic [CMD_W-1:0] ser_data;

    int checks = 0;
    int errors = 0;

    // Scoreboard entry: {cfg_ack, rt_ack, ser_data} expected at each ser_start.
    logic [CMD_W+1:0] exp_q[$];

    bit eng_on     = 1'b1;
    int eng_lat    = 10;
    int eng_cnt    = 0;
    bit force_done = 1'b0;

    always #5 clk = ~clk;

    cdce_spi_arbiter #(
        .CMD_W          (CMD_W),
        .CFG_BURST      (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .cfg_req   (cfg_req),
        .cfg_data  (cfg_data),
        .cfg_ack   (cfg_ack),
        .cfg_done  (cfg_done),
        .rt_req    (rt_req),
        .rt_data   (rt_data),
        .rt_ack    (rt_ack),
        .rt_done   (rt_done),
        .ser_start (ser_start),
        .ser_data  (ser_data),
        .ser_done  (ser_done),
        .busy      (busy),
        .timeout   (timeout)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(busy), 64'd0);
    endtask

    // Engine model: ser_done pulses eng_lat cycles after ser_start.
    always @(negedge clk) begin
        ser_done = force_done;
        if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) ser_done = 1'b1;
        end
        if (ser_start && eng_on) eng_cnt = eng_lat;
    end

    always @(negedge clk) begin
        if (reset_n && ser_start) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_start", 64'(exp_q.size()), 64'd1);
            end else begin
                logic [CMD_W+1:0] e;
                e = exp_q.pop_front();
                check("sb_owner_data", 64'({cfg_ack, rt_ack, ser_data}), 64'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        int n;
        int cyc;

        // Reset state
        smp();
        check("reset_outputs",
              64'({busy, ser_start, cfg_ack, rt_ack, cfg_done, rt_done, timeout, ser_data}),
              64'd0);
        reset_n = 1'b1;
        enable  = 1'b1;

        // Single cfg transaction, engine latency 10
        eng_lat = 10;
        step();
        cfg_data = 32'h0000_00A5;
        cfg_req  = 1'b1;
        exp_q.push_back({2'b10, 32'h0000_00A5});
        smp();
        check("t1_no_early_start", 64'(ser_start), 64'd0);
        step();
        smp();
        check("t1_start_ack", 64'({ser_start, cfg_ack, rt_ack}), 64'(3'b110));
        check("t1_ser_data", 64'(ser_data), 64'h0000_00A5);
        step();
        cfg_req = 1'b0;
        smp();
        for (int k = 1; k <= 13; k++) begin
            check("t1_cfg_done", 64'(cfg_done), 64'(k == 11));
            check("t1_rt_done", 64'(rt_done), 64'd0);
            check("t1_busy", 64'(busy), 64'(k < 12));
            if (k <= 11) check("t1_ser_data_hold", 64'(ser_data), 64'h0000_00A5);
            step();
            smp();
        end

        // Both requesters held: cfg x4, rt, cfg
        eng_lat = 3;
        step();
        cfg_data = 32'hC0C0_0001;
        rt_data  = 32'h5A5A_0002;
        for (int i = 0; i < 4; i++) exp_q.push_back({2'b10, 32'hC0C0_0001});
        exp_q.push_back({2'b01, 32'h5A5A_0002});
        exp_q.push_back({2'b10, 32'hC0C0_0001});
        cfg_req = 1'b1;
        rt_req  = 1'b1;
        n   = 0;
        cyc = 0;
        while (n < 6 && cyc < 300) begin
            smp();
            if (ser_start) n++;
            if (n < 6) step();
            cyc++;
        end
        step();
        cfg_req = 1'b0;
        rt_req  = 1'b0;
        check("t2_start_count", 64'(n), 64'd6);
        wait_idle("t2_idle");
        check("t2_queue_drained", 64'(exp_q.size()), 64'd0);

        // enable low blocks grants
        step();
        enable  = 1'b0;
        rt_data = 32'h0000_1234;
        rt_req  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            smp();
            check("t3_blocked", 64'({ser_start, busy}), 64'd0);
            step();
        end
        enable = 1'b1;
        exp_q.push_back({2'b01, 32'h0000_1234});
        smp();
        check("t3_not_yet", 64'(ser_start), 64'd0);
        step();
        smp();
        check("t3_start", 64'({ser_start, rt_ack, cfg_ack}), 64'(3'b110));
        step();
        rt_req = 1'b0;
        wait_idle("t3_idle");

        // Reset while in WAIT; request left pending restarts cleanly
        eng_on = 1'b0;
        step();
        cfg_data = 32'h0000_0BAD;
        cfg_req  = 1'b1;
        exp_q.push_back({2'b10, 32'h0000_0BAD});
        step();
        step();
        step();
        smp();
        check("t4_busy_in_wait", 64'(busy), 64'd1);
        exp_q.push_back({2'b10, 32'h0000_0BAD});
        reset_n = 1'b0;
        #1;
        check("t4_reset_outputs",
              64'({busy, ser_start, cfg_ack, cfg_done, rt_done, ser_data}), 64'd0);
        step();
        smp();
        check("t4_no_done_in_reset", 64'({cfg_done, busy}), 64'd0);
        reset_n = 1'b1;
        eng_on  = 1'b1;
        eng_lat = 3;
        smp();
        check("t4_restart", 64'({ser_start, cfg_ack, cfg_done}), 64'(3'b110));
        step();
        cfg_req = 1'b0;
        wait_idle("t4_idle");

        // Spurious ser_done in IDLE
        step();
        force_done = 1'b1;
        step();
        force_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            smp();
            check("t5_spurious", 64'({busy, cfg_done, rt_done, ser_start}), 64'd0);
            step();
        end

`ifdef CDCE_ARB_WATCHDOG_EN
        // Watchdog expiry with TIMEOUT_CYCLES=16
        eng_on = 1'b0;
        cfg_data = 32'hDEAD_0016;
        cfg_req  = 1'b1;
        exp_q.push_back({2'b10, 32'hDEAD_0016});
        step();
        smp();
        check("t6_start", 64'({ser_start, cfg_ack}), 64'(2'b11));
        step();
        cfg_req = 1'b0;
        smp();
        for (int k = 1; k <= 18; k++) begin
            check("t6_cfg_done", 64'(cfg_done), 64'(k == 17));
            check("t6_timeout", 64'(timeout), 64'(k >= 17));
            check("t6_busy", 64'(busy), 64'(k <= 17));
            step();
            smp();
        end
        eng_on  = 1'b1;
        eng_lat = 3;
        step();
        rt_data = 32'h0000_7777;
        rt_req  = 1'b1;
        exp_q.push_back({2'b01, 32'h0000_7777});
        step();
        rt_req = 1'b0;
        wait_idle("t6_idle");
        check("t6_timeout_sticky", 64'(timeout), 64'd1);
`else
        check("timeout_tied_low", 64'(timeout), 64'd0);
`endif

        check("final_queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
